// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and helpers for the rotating instruction memory
//
// Contents:
//   bank_state_e : per-bank lifecycle EMPTY -> LOADING -> READY -> ACTIVE -> EMPTY
//   ptr_next()   : modulo-N increment; works for bank counts that are not powers of two
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    ACTIVE  = 2'd3
  } bank_state_e;

  // An explicit compare is used instead of a bit-width wrap, so 3, 5, 6 or 7 banks rotate correctly.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned num_banks);
    return (ptr >= num_banks - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/imem_nbank_if.sv
// rtl/imem_nbank_if.sv - launcher write bus and PE fetch bus of the rotating instruction memory
//
// Write side (launcher -> memory): valid_i, id_i, data_i, w_switch_i; memory -> launcher: wr_ready_o
// Read side (PE -> memory): r_switch_i, rd_en_i, rd_addr_i
// Read side (memory -> PE): data_o, rd_valid_o, rd_bank_valid_o, rd_len_o, switch_pending_o
// Status: err_o (sticky dropped-write flag)
// Modports: master = launcher/PE side, slave = memory side
interface imem_nbank_if #(
  parameter int INST_WIDTH = 64,
  parameter int INST_WORD  = 32,
  parameter int ID_WIDTH   = 2
);

  logic                         valid_i;
  logic [ID_WIDTH-1:0]          id_i;
  logic [INST_WIDTH-1:0]        data_i;
  logic                         w_switch_i;
  logic                         wr_ready_o;
  logic                         r_switch_i;
  logic                         rd_en_i;
  logic [$clog2(INST_WORD)-1:0] rd_addr_i;
  logic [INST_WIDTH-1:0]        data_o;
  logic                         rd_valid_o;
  logic                         rd_bank_valid_o;
  logic [$clog2(INST_WORD):0]   rd_len_o;
  logic                         switch_pending_o;
  logic                         err_o;

  modport master (
    output valid_i, id_i, data_i, w_switch_i, r_switch_i, rd_en_i, rd_addr_i,
    input  wr_ready_o, data_o, rd_valid_o, rd_bank_valid_o, rd_len_o, switch_pending_o, err_o
  );

  modport slave (
    input  valid_i, id_i, data_i, w_switch_i, r_switch_i, rd_en_i, rd_addr_i,
    output wr_ready_o, data_o, rd_valid_o, rd_bank_valid_o, rd_len_o, switch_pending_o, err_o
  );

endinterface

// File: rtl/imem_sram_1rw.sv
// rtl/imem_sram_1rw.sv - single-port SRAM wrapper, one-cycle read latency, active-low enables
//
// Ports:
//   clk  : clock
//   ceb  : chip enable, active low
//   web  : write enable, active low (read when ceb=0 and web=1)
//   addr : word address
//   d    : write data
//   q    : read data, valid the cycle after a read; holds between reads
// Behavioural model; the synthesis flow swaps this body for the foundry macro with the same pins.
module imem_sram_1rw #(
  parameter int INST_WIDTH = 64,
  parameter int INST_WORD  = 32
) (
  input  logic                         clk,
  input  logic                         ceb,
  input  logic                         web,
  input  logic [$clog2(INST_WORD)-1:0] addr,
  input  logic [INST_WIDTH-1:0]        d,
  output logic [INST_WIDTH-1:0]        q
);

  logic [INST_WIDTH-1:0] mem [INST_WORD];

  always_ff @(posedge clk) begin
    if (!ceb) begin
      if (!web) begin
        mem[addr] <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/imem_nbank.sv
// rtl/imem_nbank.sv - N-bank rotating instruction memory between program launcher and PE fetch
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : imem_nbank_if.slave
//           write: valid_i/id_i/data_i/w_switch_i in, wr_ready_o out
//           read : r_switch_i/rd_en_i/rd_addr_i in,
//                  data_o/rd_valid_o/rd_bank_valid_o/rd_len_o/switch_pending_o out
//           err_o: sticky, set when a write addressed to this PE is dropped
// The launcher fills bank[wr_ptr] while the PE fetches from bank[rd_ptr]; a bank is only a write
// target while EMPTY or LOADING and only readable while ACTIVE, so the two sides never collide.
module imem_nbank
  import imem_pkg::*;
#(
  parameter int INST_WIDTH = 64,
  parameter int INST_WORD  = 32,
  parameter int NUM_BANKS  = 3,
  parameter int ID_WIDTH   = 2,
  parameter int ID         = 3
) (
  input logic        clk,
  input logic        rst_n,
  imem_nbank_if.slave bus
);

  localparam int AW    = $clog2(INST_WORD);
  localparam int LW    = AW + 1;
  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  bank_state_e           state_q [NUM_BANKS];
  bank_state_e           state_d [NUM_BANKS];
  logic [LW-1:0]         len_q   [NUM_BANKS];
  logic [LW-1:0]         len_d   [NUM_BANKS];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      rd_nxt;
  logic [PTR_W-1:0]      rd_bank_q;
  logic [AW-1:0]         addr_w_q, addr_w_d;
  logic                  pending_q, pending_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q;
  logic                  wr_ready, id_match, wr_fire, wr_close;
  logic                  rd_active, rd_fire, promote;
  logic [INST_WIDTH-1:0] sram_q [NUM_BANKS];

  assign wr_ready  = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == LOADING);
  assign id_match  = (bus.id_i == ID_WIDTH'(ID));
  assign wr_fire   = bus.valid_i && id_match && wr_ready;
  assign wr_close  = wr_fire && (bus.w_switch_i || (addr_w_q == AW'(INST_WORD - 1)));
  assign rd_active = (state_q[rd_ptr_q] == ACTIVE);
  assign rd_fire   = bus.rd_en_i && rd_active;
  assign rd_nxt    = PTR_W'(ptr_next(32'(rd_ptr_q), NUM_BANKS));
  // A switch request in the current cycle counts immediately; promotion still only looks at the
  // registered bank state, so a bank closed at this edge is promoted one edge later at the earliest.
  assign promote   = (pending_q || bus.r_switch_i) && (state_q[rd_nxt] == READY);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_w_d  = addr_w_q;
    pending_d = pending_q || bus.r_switch_i;
    err_d     = err_q || (bus.valid_i && id_match && !wr_ready);

    if (wr_fire) begin
      if (wr_close) begin
        state_d[wr_ptr_q] = READY;
        len_d[wr_ptr_q]   = LW'(addr_w_q) + LW'(1);
        addr_w_d          = '0;
        wr_ptr_d          = PTR_W'(ptr_next(32'(wr_ptr_q), NUM_BANKS));
      end else begin
        state_d[wr_ptr_q] = LOADING;
        addr_w_d          = addr_w_q + AW'(1);
      end
    end

    // The write target is never READY/ACTIVE, so these updates never touch the bank written above.
    if (promote) begin
      if (rd_active) begin
        state_d[rd_ptr_q] = EMPTY;
      end
      state_d[rd_nxt] = ACTIVE;
      rd_ptr_d        = rd_nxt;
      pending_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= EMPTY;
        len_q[b]   <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= PTR_W'(NUM_BANKS - 1);
      addr_w_q   <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_w_q   <= addr_w_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      rd_valid_q <= rd_fire;
      // Remember which bank was read so data_o follows the old bank across a promotion.
      if (rd_fire) begin
        rd_bank_q <= rd_ptr_q;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic          sel_w, sel_r;
      logic [AW-1:0] addr;

      assign sel_w = wr_fire && (wr_ptr_q == PTR_W'(g));
      assign sel_r = rd_fire && (rd_ptr_q == PTR_W'(g));
      assign addr  = sel_w ? addr_w_q : bus.rd_addr_i;

      imem_sram_1rw #(
        .INST_WIDTH(INST_WIDTH),
        .INST_WORD (INST_WORD)
      ) u_sram (
        .clk (clk),
        .ceb (!(sel_w || sel_r)),
        .web (!sel_w),
        .addr(addr),
        .d   (bus.data_i),
        .q   (sram_q[g])
      );
    end
  endgenerate

  assign bus.wr_ready_o       = wr_ready;
  assign bus.data_o           = rd_valid_q ? sram_q[rd_bank_q] : '0;
  assign bus.rd_valid_o       = rd_valid_q;
  assign bus.rd_bank_valid_o  = rd_active;
  assign bus.rd_len_o         = rd_active ? len_q[rd_ptr_q] : '0;
  assign bus.switch_pending_o = pending_q;
  assign bus.err_o            = err_q;

endmodule
